round_pipe: RTL and testbench

ROUND_PIPE -- requirements
Module: round_pipe

---
 rtl/round_pipe.sv | 138 +++++++++++++
 tb/tb_round_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_pipe.sv
`default_nettype none
// ============================================================================
// Module   : round_pipe
// Brief    : Two-stage IEEE-style rounding pipeline with valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module round_pipe #(
    parameter int FRAC_W = 23,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [FRAC_W-1:0] in_frac,
    input  logic [2:0]        in_grs,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_inexact,
    output logic              out_overflow
);

    localparam logic [EXP_W-1:0] c_EXP_ONES = '1;
    localparam logic [EXP_W-1:0] c_EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]       c_RNE      = 2'b00;
    localparam logic [1:0]       c_RTZ      = 2'b01;
    localparam logic [1:0]       c_RUP      = 2'b10;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_sign_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [FRAC_W-1:0] s1_frac_q;
    logic              s1_up_q;
    logic              s1_inexact_q;

    logic              s2_valid_q, s2_valid_d;
    logic              s2_sign_q;
    logic [EXP_W-1:0]  s2_exp_q;
    logic [FRAC_W-1:0] s2_frac_q;
    logic              s2_inexact_q;
    logic              s2_overflow_q;

    logic              w_pass;
    logic              w_any;
    logic              w_mode_up;
    logic              w_s2_load;
    logic [FRAC_W:0]   w_sum;
    logic [EXP_W-1:0]  w_exp_inc;
    logic [EXP_W-1:0]  w_exp_d;
    logic [FRAC_W-1:0] w_frac_d;
    logic              w_ovf_d;

    // An all-ones exponent is Inf/NaN and is forwarded without rounding.
    assign w_pass = (in_exp == c_EXP_ONES);
    assign w_any  = |in_grs;

    always_comb begin
        w_mode_up = 1'b0;
        case (in_mode)
            c_RNE:   w_mode_up = in_grs[2] & (in_grs[1] | in_grs[0] | in_frac[0]);
            c_RTZ:   w_mode_up = 1'b0;
            c_RUP:   w_mode_up = ~in_sign & w_any;
            default: w_mode_up = in_sign & w_any;
        endcase
    end

    assign w_s2_load = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready  = !s1_valid_q || w_s2_load;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        s2_valid_d = s2_valid_q;
        if (w_s2_load) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    assign w_sum     = {1'b0, s1_frac_q} + {{FRAC_W{1'b0}}, s1_up_q};
    assign w_exp_inc = s1_exp_q + c_EXP_ONE;
    // A carry out of the fraction renormalises to 1.0 x 2^(e+1).
    assign w_frac_d  = w_sum[FRAC_W] ? '0 : w_sum[FRAC_W-1:0];
    assign w_exp_d   = w_sum[FRAC_W] ? w_exp_inc : s1_exp_q;
    assign w_ovf_d   = w_sum[FRAC_W] && (w_exp_inc == c_EXP_ONES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_exp_q      <= '0;
            s1_frac_q     <= '0;
            s1_up_q       <= 1'b0;
            s1_inexact_q  <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_sign_q     <= 1'b0;
            s2_exp_q      <= '0;
            s2_frac_q     <= '0;
            s2_inexact_q  <= 1'b0;
            s2_overflow_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (in_ready && in_valid) begin
                s1_sign_q    <= in_sign;
                s1_exp_q     <= in_exp;
                s1_frac_q    <= in_frac;
                s1_up_q      <= w_mode_up & ~w_pass;
                s1_inexact_q <= w_any & ~w_pass;
            end
            if (w_s2_load) begin
                s2_sign_q     <= s1_sign_q;
                s2_exp_q      <= w_exp_d;
                s2_frac_q     <= w_frac_d;
                s2_inexact_q  <= s1_inexact_q;
                s2_overflow_q <= w_ovf_d;
            end
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_sign     = s2_sign_q;
    assign out_exp      = s2_exp_q;
    assign out_frac     = s2_frac_q;
    assign out_inexact  = s2_inexact_q;
    assign out_overflow = s2_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_round_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_round_pipe
// Brief    : Scoreboard bench for round_pipe with directed and random beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_round_pipe;

    localparam int FW = 23;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sign = 1'b0;
    logic [EW-1:0] in_exp = '0;
    logic [FW-1:0] in_frac = '0;
    logic [2:0]    in_grs = '0;
    logic [1:0]    in_mode = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_sign;
    logic [EW-1:0] out_exp;
    logic [FW-1:0] out_frac;
    logic          out_inexact;
    logic          out_overflow;

    typedef struct packed {
        logic          s;
        logic [EW-1:0] e;
        logic [FW-1:0] f;
        logic          nx;
        logic          ov;
    } res_t;

    res_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out    = 0;
    bit   rand_bp  = 1'b0;

    round_pipe #(.FRAC_W(FW), .EXP_W(EW)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_frac      (in_frac),
        .in_grs       (in_grs),
        .in_mode      (in_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sign     (out_sign),
        .out_exp      (out_exp),
        .out_frac     (out_frac),
        .out_inexact  (out_inexact),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic s, input logic [EW-1:0] e,
                                   input logic [FW-1:0] f, input logic [2:0] grs,
                                   input logic [1:0] mode);
        res_t        r;
        logic        up;
        longint      v;
        r.s  = s;
        r.e  = e;
        r.f  = f;
        r.nx = 1'b0;
        r.ov = 1'b0;
        if (e == 8'hFF) return r;
        r.nx = (grs != 3'b000);
        case (mode)
            2'd0:    up = grs[2] && (grs[1] || grs[0] || f[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = !s && r.nx;
            default: up = s && r.nx;
        endcase
        v = longint'(f) + (up ? 64'd1 : 64'd0);
        if (v >= (64'd1 << FW)) begin
            r.f  = '0;
            r.e  = e + 8'd1;
            r.ov = (r.e == 8'hFF);
        end else begin
            r.f = v[FW-1:0];
        end
        return r;
    endfunction

    res_t cur, held, expd;
    bit   held_v = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            held_v = 1'b0;
        end else begin
            cur = {out_sign, out_exp, out_frac, out_inexact, out_overflow};
            if (held_v && out_valid) check("stall_stable", 64'(cur), 64'(held));
            held_v = out_valid && !out_ready;
            held   = cur;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    expd = sb.pop_front();
                    check("result", 64'(cur), 64'(expd));
                    n_out++;
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model(in_sign, in_exp, in_frac, in_grs, in_mode));
        end
    end

    // Called 2 time units after a rising edge; returns at the same phase.
    task automatic send(input logic s, input logic [EW-1:0] e, input logic [FW-1:0] f,
                        input logic [2:0] grs, input logic [1:0] mode);
        int guard = 0;
        in_sign  = s;
        in_exp   = e;
        in_frac  = f;
        in_grs   = grs;
        in_mode  = mode;
        in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (guard >= 100) check("in_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() != 0 || out_valid) && g < 200) begin
            @(posedge clk);
            #2;
            g++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int base;
        int lat;
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'({out_sign, out_exp, out_frac, out_inexact, out_overflow}), 64'd0);
        #14 rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #2;

        send(1'b0, 8'h10, 23'h000001, 3'b100, 2'd0);
        send(1'b0, 8'h10, 23'h000002, 3'b100, 2'd0);
        send(1'b0, 8'h7F, 23'h7FFFFF, 3'b110, 2'd0);
        send(1'b0, 8'hFE, 23'h7FFFFF, 3'b110, 2'd0);
        send(1'b0, 8'h40, 23'h000010, 3'b001, 2'd1);
        send(1'b0, 8'h40, 23'h000010, 3'b001, 2'd2);
        send(1'b1, 8'h40, 23'h000010, 3'b001, 2'd2);
        send(1'b1, 8'h40, 23'h000010, 3'b001, 2'd3);
        for (int m = 0; m < 4; m++) send(m[0], 8'h55, 23'h2AAAAB, 3'b000, m[1:0]);
        send(1'b1, 8'hFF, 23'h7FFFFF, 3'b111, 2'd2);
        send(1'b0, 8'hFF, 23'h000000, 3'b100, 2'd0);
        drain();

        rand_bp = 1'b1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [EW-1:0] e;
                    logic [FW-1:0] f;
                    e = 8'($urandom_range(0, 3) == 0 ? (8'hFC + $urandom_range(0, 3)) : $urandom_range(0, 255));
                    f = 23'($urandom_range(0, 1) == 0 ? (23'h7FFFFF - $urandom_range(0, 2)) : $urandom);
                    send(1'($urandom), e, f, 3'($urandom), 2'($urandom));
                end
                rand_bp = 1'b0;
            end
            begin
                while (rand_bp) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        base = n_out;
        out_ready = 1'b0;
        send(1'b0, 8'h20, 23'h000001, 3'b100, 2'd0);
        send(1'b1, 8'h21, 23'h000003, 3'b010, 2'd3);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        fork
            for (int i = 0; i < 6; i++) send(1'b0, 8'h30 + 8'(i), 23'h7FFFF0 + 23'(i), 3'(i), 2'(i));
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_beat_count", 64'(n_out - base), 64'd8);

        send(1'b0, 8'h11, 23'h000100, 3'b101, 2'd0);
        send(1'b1, 8'h12, 23'h000200, 3'b011, 2'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_outputs", 64'({out_sign, out_exp, out_frac, out_inexact, out_overflow}), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_empty", 64'(out_valid), 64'd0);
        #1;

        in_sign  = 1'b0;
        in_exp   = 8'h33;
        in_frac  = 23'h000005;
        in_grs   = 3'b111;
        in_mode  = 2'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #2;
            lat++;
        end
        check("latency", 64'(lat), 64'd2);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
